// File: rtl/richards_pkg.sv
// Shared constants for the Richards microsequencer: select codes and the
// default divider-control tables for the 3-bit, 3-condition build.
package richards_pkg;

  localparam int DEF_STATE_W  = 3;
  localparam int DEF_NUM_COND = 3;

  localparam logic [2:0] NEVER     = 3'd0;
  localparam logic [2:0] ALWAYS    = 3'd1;
  localparam logic [2:0] COND_BASE = 3'd2;

  // Tables are packed with state 0 in the least significant slot.
  localparam logic [23:0] DEF_COND_SEL = {
    COND_BASE,          // 7: go
    NEVER,              // 6
    COND_BASE + 3'd2,   // 5: cnt_nonzero
    NEVER,              // 4
    NEVER,              // 3
    NEVER,              // 2
    COND_BASE + 3'd1,   // 1: divisor_nonzero
    COND_BASE           // 0: go
  };

  localparam logic [7:0] DEF_COND_POL = 8'b0000_0011;

  localparam logic [23:0] DEF_JUMP_TGT = {
    3'd7, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0
  };

endpackage

// File: rtl/richards_state_reg.sv
// Falling-edge state counter: async active-low reset, then load > hold > increment.
module richards_state_reg #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [STATE_W-1:0] load_value,
  input  logic               hold,
  output logic [STATE_W-1:0] count
);

  localparam logic [STATE_W-1:0] ONE = STATE_W'(1);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!hold) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/richards_sequencer.sv
// Table-driven microsequencer: each state either conditionally jumps to its
// target or steps to the next state, with stall, restart and illegal-state recovery.
module richards_sequencer
  import richards_pkg::*;
#(
  parameter int STATE_W    = DEF_STATE_W,
  parameter int LAST_STATE = 7,
  parameter int NUM_COND   = DEF_NUM_COND,
  localparam int NUM_STATES = 2 ** STATE_W,
  localparam int SEL_W      = $clog2(NUM_COND + 2),
  parameter logic [NUM_STATES*SEL_W-1:0]   COND_SEL = DEF_COND_SEL,
  parameter logic [NUM_STATES-1:0]         COND_POL = DEF_COND_POL,
  parameter logic [NUM_STATES*STATE_W-1:0] JUMP_TGT = DEF_JUMP_TGT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COND-1:0]   cond,
  input  logic                  restart,
  input  logic                  stall,
  output logic [STATE_W-1:0]    state,
  output logic [NUM_STATES-1:0] state_oh,
  output logic                  jumped,
  output logic                  err
);

  localparam logic [STATE_W-1:0] LAST_Q = STATE_W'(LAST_STATE);

  logic [(2**SEL_W)-1:0] ext_pad;
  logic [SEL_W-1:0]      sel;
  logic [STATE_W-1:0]    tgt;
  logic [STATE_W-1:0]    load_value;
  logic                  take;
  logic                  illegal;
  logic                  at_last;
  logic                  load;

  // Unused select codes land on zero padding, so they behave as "never".
  always_comb begin
    ext_pad = '0;
    ext_pad[NUM_COND+1:0] = {cond, 1'b1, 1'b0};
  end

  assign sel     = COND_SEL[int'(state)*SEL_W +: SEL_W];
  assign tgt     = JUMP_TGT[int'(state)*STATE_W +: STATE_W];
  assign take    = ext_pad[sel] ^ COND_POL[int'(state)];
  assign at_last = (state == LAST_Q);

  if (LAST_STATE < NUM_STATES - 1) begin : g_illegal
    assign illegal = (state > LAST_Q);
  end else begin : g_no_illegal
    assign illegal = 1'b0;
  end

  assign load = restart | illegal | (~stall & (take | at_last));

  always_comb begin
    if (restart | illegal) begin
      load_value = '0;
    end else if (take) begin
      load_value = tgt;
    end else begin
      load_value = '0;
    end
  end

  richards_state_reg #(
    .STATE_W (STATE_W)
  ) u_state_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .hold       (stall),
    .count      (state)
  );

  // jumped reflects only the edge just taken; err is sticky until reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      jumped <= 1'b0;
      err    <= 1'b0;
    end else begin
      jumped <= ~restart & ~illegal & ~stall & take;
      err    <= err | illegal;
    end
  end

  always_comb begin
    state_oh = '0;
    if (!illegal) begin
      state_oh[state] = 1'b1;
    end else begin
      state_oh = '0;
    end
  end

endmodule

// File: tb/tb_richards_sequencer.sv
// Directed bench for richards_sequencer: default divider build, an illegal-state
// build (LAST_STATE=5) and a generalised 4-bit / 5-condition build.
module tb_richards_sequencer;

  logic       clk = 1'b1;
  logic       reset;
  logic       restart;
  logic       stall;
  logic [2:0] cond;
  logic [2:0] cond_i;
  logic [4:0] cond_g;

  logic [2:0]  state, state_i;
  logic [7:0]  state_oh, state_oh_i;
  logic        jumped, err, jumped_i, err_i, jumped_g, err_g;
  logic [3:0]  state_g;
  logic [15:0] state_oh_g;

  localparam logic [23:0] ILL_SEL = 24'd2;
  localparam logic [7:0]  ILL_POL = 8'h00;
  localparam logic [23:0] ILL_TGT = 24'd6;

  localparam logic [47:0] GEN_SEL = (48'd6 << 27) | (48'd7 << 30);
  localparam logic [15:0] GEN_POL = 16'h0000;
  localparam logic [63:0] GEN_TGT = (64'd12 << 36) | (64'd14 << 40);

  always #5 clk = ~clk;

  richards_sequencer dut (
    .clk(clk), .reset(reset), .cond(cond), .restart(restart), .stall(stall),
    .state(state), .state_oh(state_oh), .jumped(jumped), .err(err)
  );

  richards_sequencer #(
    .STATE_W(3), .LAST_STATE(5), .NUM_COND(3),
    .COND_SEL(ILL_SEL), .COND_POL(ILL_POL), .JUMP_TGT(ILL_TGT)
  ) dut_ill (
    .clk(clk), .reset(reset), .cond(cond_i), .restart(restart), .stall(stall),
    .state(state_i), .state_oh(state_oh_i), .jumped(jumped_i), .err(err_i)
  );

  richards_sequencer #(
    .STATE_W(4), .LAST_STATE(15), .NUM_COND(5),
    .COND_SEL(GEN_SEL), .COND_POL(GEN_POL), .JUMP_TGT(GEN_TGT)
  ) dut_gen (
    .clk(clk), .reset(reset), .cond(cond_g), .restart(restart), .stall(stall),
    .state(state_g), .state_oh(state_oh_g), .jumped(jumped_g), .err(err_g)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  int exp_seq [14] = '{1, 2, 3, 4, 5, 3, 4, 5, 3, 4, 5, 6, 7, 0};
  int exp_jmp [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    reset   = 1'b0;
    restart = 1'b0;
    stall   = 1'b0;
    cond    = 3'b011;
    cond_i  = 3'b000;
    cond_g  = 5'b00000;
    #1;
    chk("rst_state", state, 0);
    chk("rst_oh", state_oh, 8'b0000_0001);
    chk("rst_jumped", jumped, 0);
    chk("rst_err", err, 0);
    #1;
    reset = 1'b1;

    // Full pass: go dropped after state 1, cnt_nonzero for two visits of 5.
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("pass_state[%0d]", i), state, exp_seq[i]);
      chk($sformatf("pass_oh[%0d]", i), state_oh, 32'd1 << exp_seq[i]);
      chk($sformatf("pass_jumped[%0d]", i), jumped, exp_jmp[i]);
      if (i == 0) cond = 3'b110;
      if (i == 10) cond = 3'b010;
    end
    tick();
    chk("wait_go_state", state, 0);
    chk("wait_go_jumped", jumped, 1);

    // Zero divisor.
    cond = 3'b001;
    tick();
    chk("zdiv_s1", state, 1);
    chk("zdiv_j1", jumped, 0);
    tick();
    chk("zdiv_s3", state, 3);
    chk("zdiv_j3", jumped, 1);
    tick();
    chk("to4_state", state, 4);

    // Stall holds, restart beats stall.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_state[%0d]", i), state, 4);
      chk($sformatf("stall_jumped[%0d]", i), jumped, 0);
    end
    restart = 1'b1;
    tick();
    chk("restart_state", state, 0);
    chk("restart_jumped", jumped, 0);
    restart = 1'b0;
    stall   = 1'b0;

    // Reset between edges while in state 5.
    cond = 3'b011;
    repeat (5) tick();
    chk("pre_rst_state", state, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_oh", state_oh, 8'b0000_0001);
    chk("mid_rst_jumped", jumped, 0);
    #2;
    reset = 1'b1;
    tick();
    chk("post_rst_state", state, 1);

    // Illegal state via a jump past LAST_STATE.
    pulse_reset();
    cond_i = 3'b001;
    tick();
    chk("ill_state6", state_i, 6);
    chk("ill_oh_zero", state_oh_i, 0);
    chk("ill_err_pre", err_i, 0);
    tick();
    chk("ill_recover", state_i, 0);
    chk("ill_err_set", err_i, 1);
    chk("ill_jumped", jumped_i, 0);
    cond_i  = 3'b000;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("ill_err_restart", err_i, 1);
    chk("ill_state_restart", state_i, 0);
    pulse_reset();
    #1;
    chk("ill_err_reset", err_i, 0);

    // Generalised build: state 9 jumps to 12 on cond[4].
    cond_g = 5'b00000;
    repeat (9) tick();
    chk("gen_at9_a", state_g, 9);
    cond_g = 5'b10000;
    tick();
    chk("gen_jump12", state_g, 12);
    chk("gen_jump12_j", jumped_g, 1);
    pulse_reset();
    cond_g = 5'b00000;
    repeat (9) tick();
    chk("gen_at9_b", state_g, 9);
    cond_g = 5'b01111;
    tick();
    chk("gen_step10", state_g, 10);
    chk("gen_step10_j", jumped_g, 0);
    cond_g = 5'b11111;
    tick();
    chk("gen_badsel_step", state_g, 11);
    chk("gen_badsel_j", jumped_g, 0);
    chk("gen_err", err_g, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
